// File: rtl/mult_controller.sv
// Control FSM for the 3x3 repeated-addition multiplier datapath (load, clear, add loop, store).
// Define MULT_CTRL_WDOG_EN to add the ADD-loop watchdog that aborts to STORE and raises ERR.
module mult_controller (
  input  logic       SYS_CLOCK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic [2:0] B,
  input  logic       R2_LT_B,
  output logic       LOAD_A_REG,
  output logic       LOAD_B_REG,
  output logic       LOAD_R1_REG,
  output logic       LOAD_F_REG,
  output logic       MUX_IN1_CONT,
  output logic       ALU_CONT,
  output logic       SCLR,
  output logic       INC,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   b_zero;
  logic   wdog_trip;

  // RESET_N gates the Mealy IDLE outputs so everything reads 0 while reset is held
  assign accept = (state == ST_IDLE) && START && RESET_N;

  always_ff @(posedge SYS_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_IDLE;
      b_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        b_zero <= (B == 3'b000);
      end
    end
  end

`ifdef MULT_CTRL_WDOG_EN
  localparam int unsigned WDOG_W = 3;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(6);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              err_q;

  // Counter holds the number of ADD cycles already completed; 6 means this is the 7th
  assign wdog_trip = (state == ST_ADD) && R2_LT_B && (wdog_cnt == WDOG_LAST);

  always_ff @(posedge SYS_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ST_ADD) begin
        wdog_cnt <= wdog_cnt + WDOG_W'(1);
      end else begin
        wdog_cnt <= '0;
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (wdog_trip) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ERR = err_q;
`else
  assign wdog_trip = 1'b0;
  assign ERR       = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    LOAD_A_REG   = 1'b0;
    LOAD_B_REG   = 1'b0;
    LOAD_R1_REG  = 1'b0;
    LOAD_F_REG   = 1'b0;
    MUX_IN1_CONT = 1'b0;
    ALU_CONT     = 1'b0;
    SCLR         = 1'b0;
    INC          = 1'b0;
    BUSY         = 1'b0;
    DONE         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          LOAD_A_REG  = 1'b1;
          LOAD_B_REG  = 1'b1;
          LOAD_R1_REG = 1'b1;
          ALU_CONT    = 1'b1;
          SCLR        = 1'b1;
          state_nxt   = (B == 3'b000) ? ST_STORE : ST_ADD;
        end
      end
      ST_ADD: begin
        BUSY        = 1'b1;
        LOAD_R1_REG = 1'b1;
        // b_zero never reaches ADD normally; it only guards against looping on a zero multiplier
        if (R2_LT_B && !b_zero && !wdog_trip) begin
          INC = 1'b1;
        end else begin
          state_nxt = ST_STORE;
        end
      end
      ST_STORE: begin
        BUSY       = 1'b1;
        LOAD_F_REG = 1'b1;
        state_nxt  = ST_DONE;
      end
      ST_DONE: begin
        BUSY      = 1'b1;
        DONE      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_controller.sv
// Self-checking bench for mult_controller: cycle table, corner sequences, and randomized
// multiplies through a behavioural datapath checked against a timeline/product model.
`timescale 1ns/1ps
module tb_mult_controller;

  logic       sys_clock = 1'b0;
  logic       reset_n   = 1'b0;
  logic       start     = 1'b0;
  logic [2:0] b_bus     = 3'd0;
  logic [2:0] a_bus     = 3'd0;
  logic       r2_lt_b;
  logic       load_a, load_b, load_r1, load_f, mux_in1, alu_cont, sclr, inc, busy, done, err;

  always #5 sys_clock = ~sys_clock;

  mult_controller dut (
    .SYS_CLOCK   (sys_clock),
    .RESET_N     (reset_n),
    .START       (start),
    .B           (b_bus),
    .R2_LT_B     (r2_lt_b),
    .LOAD_A_REG  (load_a),
    .LOAD_B_REG  (load_b),
    .LOAD_R1_REG (load_r1),
    .LOAD_F_REG  (load_f),
    .MUX_IN1_CONT(mux_in1),
    .ALU_CONT    (alu_cont),
    .SCLR        (sclr),
    .INC         (inc),
    .BUSY        (busy),
    .DONE        (done),
    .ERR         (err)
  );

  // Behavioural datapath so products can be observed end to end
  logic       dp_mode  = 1'b0;
  logic       r2_force = 1'b0;
  logic [2:0] a_reg = 3'd0, b_reg = 3'd0;
  logic [5:0] r1 = 6'd0, f_reg = 6'd0;
  logic [3:0] q = 4'd0;

  assign r2_lt_b = dp_mode ? (q < {1'b0, b_reg}) : r2_force;

  always @(posedge sys_clock) begin
    if (load_a)  a_reg <= a_bus;
    if (load_b)  b_reg <= b_bus;
    if (load_r1) r1 <= alu_cont ? 6'd0 : r1 + {3'b000, a_reg};
    if (sclr)    q <= 4'd1;
    else if (inc) q <= q + 4'd1;
    if (load_f)  f_reg <= r1;
  end

  localparam logic [10:0] M_LA   = 11'h400, M_LB   = 11'h200, M_LR1  = 11'h100;
  localparam logic [10:0] M_LF   = 11'h080, M_ALU  = 11'h020;
  localparam logic [10:0] M_SCLR = 11'h010, M_INC  = 11'h008, M_BUSY = 11'h004;
  localparam logic [10:0] M_DONE = 11'h002, M_ERR  = 11'h001;
  localparam logic [10:0] O_LD   = M_LA | M_LB | M_LR1 | M_ALU | M_SCLR;
  localparam logic [10:0] O_ADDI = M_LR1 | M_INC | M_BUSY;
  localparam logic [10:0] O_ADDN = M_LR1 | M_BUSY;
  localparam logic [10:0] O_STO  = M_LF | M_BUSY;
  localparam logic [10:0] O_DN   = M_DONE | M_BUSY;

  int nvec = 0;
  int nmis = 0;

  function automatic logic [10:0] outs();
    return {load_a, load_b, load_r1, load_f, mux_in1, alu_cont, sclr, inc, busy, done, err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       start;
    logic [2:0] b;
    logic       r2;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[16];

  // One multiply through the datapath; START optionally poked while busy
  task automatic run_mult(input logic [2:0] a, input logic [2:0] b, input bit poke);
    int lat;
    lat = -1;
    @(negedge sys_clock);
    start = 1'b1; a_bus = a; b_bus = b;
    for (int c = 1; c <= 20; c++) begin
      @(negedge sys_clock);
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      a_bus = 3'($urandom);
      b_bus = 3'($urandom);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    chk($sformatf("mult_lat a=%0d b=%0d", a, b), 32'(lat), 32'(b) + 32'd2);
    chk($sformatf("mult_prod a=%0d b=%0d", a, b), 32'(f_reg), 32'(a) * 32'(b));
    start = 1'b0;
  endtask

  initial begin
    int done_cyc[$];
    int busy_left, gap, tx, cyc;
    logic [2:0] ra, rb;
    logic [5:0] prod;
    logic acc;

    // cycle table from IDLE: B=3 with R2 1,1,0; B=0; B=1; START pokes while busy
    tbl[0]  = '{1'b0, 3'd3, 1'b0, 11'h000};
    tbl[1]  = '{1'b1, 3'd3, 1'b0, O_LD};
    tbl[2]  = '{1'b0, 3'd0, 1'b1, O_ADDI};
    tbl[3]  = '{1'b1, 3'd0, 1'b1, O_ADDI};
    tbl[4]  = '{1'b0, 3'd5, 1'b0, O_ADDN};
    tbl[5]  = '{1'b0, 3'd0, 1'b1, O_STO};
    tbl[6]  = '{1'b1, 3'd2, 1'b1, O_DN};
    tbl[7]  = '{1'b0, 3'd0, 1'b0, 11'h000};
    tbl[8]  = '{1'b1, 3'd0, 1'b1, O_LD};
    tbl[9]  = '{1'b0, 3'd4, 1'b1, O_STO};
    tbl[10] = '{1'b0, 3'd0, 1'b1, O_DN};
    tbl[11] = '{1'b1, 3'd1, 1'b0, O_LD};
    tbl[12] = '{1'b1, 3'd7, 1'b0, O_ADDN};
    tbl[13] = '{1'b1, 3'd0, 1'b1, O_STO};
    tbl[14] = '{1'b0, 3'd0, 1'b0, O_DN};
    tbl[15] = '{1'b0, 3'd6, 1'b1, 11'h000};

    // reset state, START ignored while reset is held
    repeat (2) @(negedge sys_clock);
    start = 1'b1; b_bus = 3'd3;
    #1 chk("reset_outs", 32'(outs()), 32'd0);
    start = 1'b0;
    @(negedge sys_clock);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge sys_clock);
      start = tbl[i].start; b_bus = tbl[i].b; r2_force = tbl[i].r2;
      #1 chk($sformatf("tbl[%0d]", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // reset asserted during the 2nd ADD cycle
    @(negedge sys_clock);
    start = 1'b1; b_bus = 3'd5; r2_force = 1'b1;
    #1 chk("rst_seq_load", 32'(outs()), 32'(O_LD));
    @(negedge sys_clock);
    start = 1'b0;
    #1 chk("rst_seq_add1", 32'(outs()), 32'(O_ADDI));
    @(negedge sys_clock);
    #1 chk("rst_seq_add2", 32'(outs()), 32'(O_ADDI));
    #1 reset_n = 1'b0; start = 1'b1;
    #1 chk("rst_mid_add", 32'(outs()), 32'd0);
    @(negedge sys_clock);
    reset_n = 1'b1; start = 1'b0;
    #1 chk("rst_release_busy", 32'(busy), 32'd0);
    @(negedge sys_clock);
    #1 chk("rst_idle", 32'(outs()), 32'd0);

    // directed products through the datapath
    dp_mode = 1'b1;
    run_mult(3'd5, 3'd7, 1'b0);
    run_mult(3'd7, 3'd7, 1'b1);
    run_mult(3'd0, 3'd4, 1'b1);
    run_mult(3'd6, 3'd0, 1'b0);
    run_mult(3'd6, 3'd1, 1'b0);

    // START held high: DONE every B+3 cycles
    @(negedge sys_clock);
    start = 1'b1; a_bus = 3'd3; b_bus = 3'd2;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (done) begin
        done_cyc.push_back(c);
        chk("held_prod", 32'(f_reg), 32'd6);
      end
      @(negedge sys_clock);
    end
    start = 1'b0;
    chk("held_count", 32'(done_cyc.size()), 32'd4);
    for (int k = 1; k < done_cyc.size(); k++)
      chk("held_spacing", 32'(done_cyc[k] - done_cyc[k-1]), 32'd5);
    repeat (6) @(negedge sys_clock);

    // randomized multiplies against a timeline/product model
    busy_left = 0; gap = 0; tx = 0; cyc = 0; prod = 6'd0; ra = 3'd0; rb = 3'd0;
    while (tx < 40 && cyc < 3000) begin
      @(negedge sys_clock);
      cyc++;
      acc = (busy_left == 0) && (gap == 0);
      if (acc) begin
        ra = 3'($urandom_range(0, 7));
        rb = 3'($urandom_range(0, 7));
        start = 1'b1; a_bus = ra; b_bus = rb;
      end else begin
        start = (busy_left > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        a_bus = 3'($urandom);
        b_bus = 3'($urandom);
      end
      #1;
      chk("rnd_busy", 32'(busy), 32'(busy_left > 0));
      chk("rnd_done", 32'(done), 32'(busy_left == 1));
      chk("rnd_load", 32'(load_a), 32'(acc));
      if (busy_left == 1) chk($sformatf("rnd_prod tx=%0d", tx), 32'(f_reg), 32'(prod));
      if (busy_left > 0) busy_left--;
      else if (gap > 0) gap--;
      if (acc) begin
        busy_left = 32'(rb) + 2;
        prod = 6'(ra) * 6'(rb);
        gap = $urandom_range(0, 3);
        tx++;
      end
    end
    chk("rnd_tx_done", 32'(tx), 32'd40);
    while (busy_left > 0) begin
      @(negedge sys_clock);
      start = 1'b0;
      busy_left--;
    end
    @(negedge sys_clock);
    #1 chk("rnd_end_idle", 32'(busy), 32'd0);

    // R2_LT_B stuck high
    dp_mode = 1'b0; r2_force = 1'b1;
    @(negedge sys_clock);
    start = 1'b1; b_bus = 3'd7;
    #1 chk("stuck_load", 32'(outs()), 32'(O_LD));
    @(negedge sys_clock);
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1 chk($sformatf("stuck_add%0d", c), 32'(outs()), 32'(O_ADDI));
      @(negedge sys_clock);
    end
`ifdef MULT_CTRL_WDOG_EN
    #1 chk("wdog_add7", 32'(outs()), 32'(O_ADDN));
    @(negedge sys_clock);
    #1 chk("wdog_store", 32'(outs()), 32'(O_STO | M_ERR));
    @(negedge sys_clock);
    #1 chk("wdog_done", 32'(outs()), 32'(O_DN | M_ERR));
    @(negedge sys_clock);
    #1 chk("wdog_idle_err", 32'(outs()), 32'(M_ERR));
    @(negedge sys_clock);
    start = 1'b1; b_bus = 3'd1;
    #1 chk("wdog_restart", 32'(outs()), 32'(O_LD | M_ERR));
    @(negedge sys_clock);
    start = 1'b0; r2_force = 1'b0;
    #1 chk("wdog_err_clr", 32'(outs()), 32'(O_ADDN));
    @(negedge sys_clock);
    #1 chk("wdog_store2", 32'(outs()), 32'(O_STO));
    @(negedge sys_clock);
    #1 chk("wdog_done2", 32'(outs()), 32'(O_DN));
`else
    for (int c = 7; c <= 16; c++) begin
      #1 chk($sformatf("stuck_add%0d", c), 32'(outs()), 32'(O_ADDI));
      @(negedge sys_clock);
    end
    reset_n = 1'b0;
    #1 chk("stuck_reset", 32'(outs()), 32'd0);
    @(negedge sys_clock);
    reset_n = 1'b1;
    #1 chk("stuck_idle", 32'(outs()), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
